calc_op_sequencer: RTL and testbench



---
 rtl/calc_pkg.sv | 55 +++++
 rtl/calc_digit_acc.sv | 52 +++++
 rtl/calc_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command sequencer.
// Key codes, ALU operator encoding, FSM states and display status codes.
package calc_pkg;

    localparam int DATA_W     = 27;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_VAL    = 99_999_999;
    localparam int CNT_W      = 4;

    // Key codes 0-9 are digits and carry no enum member.
    typedef enum logic [3:0] {
        CMD_ADD = 4'b1010,
        CMD_SUB = 4'b1011,
        CMD_MUL = 4'b1100,
        CMD_NOP = 4'b1101,
        CMD_EQ  = 4'b1110,
        CMD_CLR = 4'b1111
    } cmd_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_OP_WAIT = 3'd1,
        S_ENTER_B = 3'd2,
        S_EXEC    = 3'd3,
        S_RESULT  = 3'd4,
        S_ERROR   = 3'd5
    } state_e;

    localparam logic [1:0] ST_READY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_ERR   = 2'b10;

    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] c);
        return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_MUL);
    endfunction

    function automatic op_e cmd_to_op(input logic [3:0] c);
        case (c)
            CMD_SUB: return OP_SUB;
            CMD_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal operand register: clear, parallel load, and value*10+digit entry.
// A saturating digit counter stops accumulation once MAX_D digits are held.
module calc_digit_acc
    import calc_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int MAX_D = MAX_DIGITS
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         digit_en,
    input  logic         start,
    input  logic [3:0]   digit,
    output logic [W-1:0] value,
    output logic [W-1:0] next_value
);

    logic [CNT_W-1:0] count;
    logic             full;

    assign full = (count >= CNT_W'(MAX_D));

    // next_value is what a digit would produce; the top also shows it on the display.
    always_comb begin
        next_value = value;
        if (start) begin
            next_value = W'(digit);
        end else if (!full) begin
            next_value = value * W'(10) + W'(digit);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_value;
            count <= '0;
        end else if (digit_en) begin
            value <= next_value;
            if (start) begin
                count <= CNT_W'(1);
            end else if (!full) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Keypad-to-ALU control FSM: builds operands, latches the operator, runs one
// ALU transaction per EQ/chained op and publishes display value and status.
module calc_op_sequencer
    import calc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              alu_start,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W:0]   alu_result,
    output logic [DATA_W-1:0] disp_value,
    output logic [1:0]        status,
    output logic [2:0]        state
);

    // Handshake: a command transfers on a cycle with cmd_valid && cmd_ready;
    // cmd_ready is low only while an ALU transaction is outstanding, and
    // commands offered then are dropped rather than held.

    state_e            state_q;
    op_e               op_q;
    op_e               next_op_q;
    logic              chain_q;
    logic              done_seen_q;
    logic [DATA_W:0]   res_q;

    logic              accept;
    logic              digit_cmd;
    logic              op_cmd;
    logic              eq_cmd;
    logic              clr_now;
    logic              exec_finish;
    logic              res_ok;

    logic              acc_clear;
    logic              a_load;
    logic              a_digit_en;
    logic              a_start;
    logic              b_digit_en;
    logic              b_start;
    logic [DATA_W-1:0] a_value;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_value;
    logic [DATA_W-1:0] b_next;

    assign cmd_ready   = (state_q != S_EXEC);
    assign accept      = cmd_valid && cmd_ready;
    assign digit_cmd   = accept && is_digit(cmd);
    assign op_cmd      = accept && is_op(cmd);
    assign eq_cmd      = accept && (cmd == CMD_EQ);
    assign clr_now     = accept && (cmd == CMD_CLR);
    assign exec_finish = (state_q == S_EXEC) && done_seen_q;
    assign res_ok      = !res_q[DATA_W] && (res_q[DATA_W-1:0] <= DATA_W'(MAX_VAL));

    // Digits after a state change into an entry state restart the operand.
    assign acc_clear  = reset || clr_now;
    assign a_load     = exec_finish && res_ok;
    assign a_digit_en = digit_cmd && ((state_q == S_ENTER_A) || (state_q == S_RESULT));
    assign a_start    = (state_q == S_RESULT);
    assign b_digit_en = digit_cmd && ((state_q == S_OP_WAIT) || (state_q == S_ENTER_B));
    assign b_start    = (state_q == S_OP_WAIT);

    calc_digit_acc #(.W(DATA_W), .MAX_D(MAX_DIGITS)) u_acc_a (
        .clock      (clock),
        .clear      (acc_clear),
        .load       (a_load),
        .load_value (res_q[DATA_W-1:0]),
        .digit_en   (a_digit_en),
        .start      (a_start),
        .digit      (cmd),
        .value      (a_value),
        .next_value (a_next)
    );

    calc_digit_acc #(.W(DATA_W), .MAX_D(MAX_DIGITS)) u_acc_b (
        .clock      (clock),
        .clear      (acc_clear),
        .load       (1'b0),
        .load_value ('0),
        .digit_en   (b_digit_en),
        .start      (b_start),
        .digit      (cmd),
        .value      (b_value),
        .next_value (b_next)
    );

    assign alu_a  = a_value;
    assign alu_b  = b_value;
    assign alu_op = op_q;
    assign state  = state_q;

    always_ff @(posedge clock) begin
        alu_start <= 1'b0;
        if (reset || clr_now) begin
            state_q     <= S_ENTER_A;
            op_q        <= OP_ADD;
            next_op_q   <= OP_ADD;
            chain_q     <= 1'b0;
            done_seen_q <= 1'b0;
            res_q       <= '0;
            disp_value  <= '0;
            status      <= ST_READY;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (digit_cmd) begin
                        disp_value <= a_next;
                    end else if (op_cmd) begin
                        op_q    <= cmd_to_op(cmd);
                        state_q <= S_OP_WAIT;
                    end
                end
                S_OP_WAIT: begin
                    if (digit_cmd) begin
                        disp_value <= b_next;
                        state_q    <= S_ENTER_B;
                    end else if (op_cmd) begin
                        op_q <= cmd_to_op(cmd);
                    end
                end
                S_ENTER_B: begin
                    if (digit_cmd) begin
                        disp_value <= b_next;
                    end else if (eq_cmd || op_cmd) begin
                        chain_q     <= op_cmd;
                        next_op_q   <= cmd_to_op(cmd);
                        done_seen_q <= 1'b0;
                        alu_start   <= 1'b1;
                        status      <= ST_BUSY;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // The result is captured first and judged on the following edge.
                    if (!done_seen_q) begin
                        if (alu_done) begin
                            res_q       <= alu_result;
                            done_seen_q <= 1'b1;
                        end
                    end else begin
                        done_seen_q <= 1'b0;
                        if (!res_ok) begin
                            disp_value <= '0;
                            status     <= ST_ERR;
                            state_q    <= S_ERROR;
                        end else begin
                            disp_value <= res_q[DATA_W-1:0];
                            status     <= ST_READY;
                            if (chain_q) begin
                                op_q    <= next_op_q;
                                state_q <= S_OP_WAIT;
                            end else begin
                                state_q <= S_RESULT;
                            end
                        end
                    end
                end
                S_RESULT: begin
                    if (digit_cmd) begin
                        disp_value <= a_next;
                        state_q    <= S_ENTER_A;
                    end else if (op_cmd) begin
                        op_q    <= cmd_to_op(cmd);
                        state_q <= S_OP_WAIT;
                    end
                end
                S_ERROR: begin
                end
                default: begin
                    state_q <= S_ENTER_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: scripted keypad table, hand-written corner
// sequences, and a 4-cycle ALU model that checks each transaction it receives.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        cmd = 4'd0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              alu_start;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_done = 1'b0;
    logic [DATA_W:0]   alu_result = '0;
    logic [DATA_W-1:0] disp_value;
    logic [1:0]        status;
    logic [2:0]        state;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int pushed = 0;
    int start_count = 0;
    bit abort_expected = 1'b0;
    bit inject_on_done = 1'b0;
    logic [3:0] inject_cmd = 4'd0;

    logic [55:0] exp_q[$];

    typedef struct {
        logic [3:0] c;
        bit         alu;
        logic [1:0] op;
        int         a;
        int         b;
        int         disp;
        logic [1:0] st;
        logic [2:0] sv;
    } vec_t;
    vec_t vecs[$];

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    calc_op_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .disp_value (disp_value),
        .status     (status),
        .state      (state)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [55:0] pack_txn(input logic [1:0] op, input int a, input int b);
        return {op, DATA_W'(a), DATA_W'(b)};
    endfunction

    // driver tasks
    task automatic send_cmd(input logic [3:0] c);
        @(negedge clock);
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_exec(input string name);
        int n = 0;
        while (state == S_EXEC && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (state != S_EXEC) passes++;
        else $display("FAIL %s: still in S_EXEC after %0d cycles, expected exit", name, n);
    endtask

    task automatic add(input logic [3:0] c, input int disp, input logic [1:0] st, input logic [2:0] sv);
        vec_t v;
        v.c = c; v.alu = 1'b0; v.op = 2'b00; v.a = 0; v.b = 0;
        v.disp = disp; v.st = st; v.sv = sv;
        vecs.push_back(v);
    endtask

    task automatic add_alu(input logic [3:0] c, input logic [1:0] op, input int a, input int b,
                           input int disp, input logic [1:0] st, input logic [2:0] sv);
        vec_t v;
        v.c = c; v.alu = 1'b1; v.op = op; v.a = a; v.b = b;
        v.disp = disp; v.st = st; v.sv = sv;
        vecs.push_back(v);
    endtask

    // ALU model: fixed 4-cycle latency; scoreboard pops the expected transaction on alu_start
    initial begin : alu_model
        bit          pending = 1'b0;
        bit          injected = 1'b0;
        int          wait_n = 0;
        logic [55:0] held = '0;
        longint      rr = 0;
        forever begin
            @(negedge clock);
            alu_done = 1'b0;
            if (injected) begin
                cmd_valid = 1'b0;
                injected  = 1'b0;
            end
            if (pending) begin
                wait_n--;
                if (wait_n == 0) begin
                    pending = 1'b0;
                    if (!abort_expected)
                        check("alu_operands_stable", {alu_op, alu_a, alu_b}, held);
                    alu_done   = 1'b1;
                    alu_result = rr[DATA_W:0];
                    if (inject_on_done) begin
                        cmd            = inject_cmd;
                        cmd_valid      = 1'b1;
                        injected       = 1'b1;
                        inject_on_done = 1'b0;
                    end
                end
            end
            if (alu_start) begin
                start_count++;
                held = {alu_op, alu_a, alu_b};
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL alu_txn: unexpected start op=%0d a=%0d b=%0d, expected none",
                             alu_op, alu_a, alu_b);
                end else begin
                    check("alu_txn", held, exp_q.pop_front());
                end
                case (alu_op)
                    2'b00:   rr = longint'(alu_a) + longint'(alu_b);
                    2'b01:   rr = longint'(alu_a) - longint'(alu_b);
                    default: rr = longint'(alu_a) * longint'(alu_b);
                endcase
                if (rr > 134217727) rr = 134217727;
                pending = 1'b1;
                wait_n  = 4;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : test
        int v;
        int c0;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_disp", disp_value, 0);
        check("reset_status", status, ST_READY);
        check("reset_state", state, S_ENTER_A);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_alu_start", alu_start, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_alu_op", alu_op, OP_ADD);

        // 1,2,ADD,3,EQ
        add(4'd1, 1, ST_READY, S_ENTER_A);
        add(4'd2, 12, ST_READY, S_ENTER_A);
        add(CMD_ADD, 12, ST_READY, S_OP_WAIT);
        add(4'd3, 3, ST_READY, S_ENTER_B);
        add_alu(CMD_EQ, OP_ADD, 12, 3, 15, ST_READY, S_RESULT);
        // new A from result state, negative result, error lock-out, CLR
        add(4'd3, 3, ST_READY, S_ENTER_A);
        add(CMD_SUB, 3, ST_READY, S_OP_WAIT);
        add(4'd5, 5, ST_READY, S_ENTER_B);
        add_alu(CMD_EQ, OP_SUB, 3, 5, 0, ST_ERR, S_ERROR);
        add(4'd7, 0, ST_ERR, S_ERROR);
        add(CMD_EQ, 0, ST_ERR, S_ERROR);
        add(CMD_ADD, 0, ST_ERR, S_ERROR);
        add(CMD_CLR, 0, ST_READY, S_ENTER_A);
        // nine 9s: ninth dropped, then overflow via MUL
        v = 0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) v = v * 10 + 9;
            add(4'd9, v, ST_READY, S_ENTER_A);
        end
        add(CMD_MUL, 99_999_999, ST_READY, S_OP_WAIT);
        add(4'd2, 2, ST_READY, S_ENTER_B);
        add_alu(CMD_EQ, OP_MUL, 99_999_999, 2, 0, ST_ERR, S_ERROR);
        add(CMD_CLR, 0, ST_READY, S_ENTER_A);
        // chained 2,ADD,3,ADD,4,EQ
        add(4'd2, 2, ST_READY, S_ENTER_A);
        add(CMD_ADD, 2, ST_READY, S_OP_WAIT);
        add(4'd3, 3, ST_READY, S_ENTER_B);
        add_alu(CMD_ADD, OP_ADD, 2, 3, 5, ST_READY, S_OP_WAIT);
        add(4'd4, 4, ST_READY, S_ENTER_B);
        add_alu(CMD_EQ, OP_ADD, 5, 4, 9, ST_READY, S_RESULT);
        // op from result keeps A; op replacement; ignored codes; EQ no-ops
        add(CMD_MUL, 9, ST_READY, S_OP_WAIT);
        add(CMD_EQ, 9, ST_READY, S_OP_WAIT);
        add(CMD_SUB, 9, ST_READY, S_OP_WAIT);
        add(CMD_NOP, 9, ST_READY, S_OP_WAIT);
        add(4'd4, 4, ST_READY, S_ENTER_B);
        add(CMD_NOP, 4, ST_READY, S_ENTER_B);
        add_alu(CMD_EQ, OP_SUB, 9, 4, 5, ST_READY, S_RESULT);
        add(CMD_EQ, 5, ST_READY, S_RESULT);
        // leading zeros count toward the digit limit
        add(CMD_CLR, 0, ST_READY, S_ENTER_A);
        add(CMD_EQ, 0, ST_READY, S_ENTER_A);
        add(4'd0, 0, ST_READY, S_ENTER_A);
        add(4'd0, 0, ST_READY, S_ENTER_A);
        v = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) v = v * 10 + 9;
            add(4'd9, v, ST_READY, S_ENTER_A);
        end
        add(CMD_ADD, 999_999, ST_READY, S_OP_WAIT);
        add(CMD_CLR, 0, ST_READY, S_ENTER_A);
        // exact MAX_VAL is not overflow; zero result is not negative
        v = 0;
        for (int k = 0; k < 8; k++) begin
            v = v * 10 + ((k < 7) ? 9 : 8);
            add((k < 7) ? 4'd9 : 4'd8, v, ST_READY, S_ENTER_A);
        end
        add(CMD_ADD, 99_999_998, ST_READY, S_OP_WAIT);
        add(4'd1, 1, ST_READY, S_ENTER_B);
        add_alu(CMD_EQ, OP_ADD, 99_999_998, 1, 99_999_999, ST_READY, S_RESULT);
        add(CMD_SUB, 99_999_999, ST_READY, S_OP_WAIT);
        add(4'd9, 9, ST_READY, S_ENTER_B);
        add_alu(CMD_EQ, OP_SUB, 99_999_999, 9, 99_999_990, ST_READY, S_RESULT);
        add(4'd5, 5, ST_READY, S_ENTER_A);
        add(CMD_SUB, 5, ST_READY, S_OP_WAIT);
        add(4'd5, 5, ST_READY, S_ENTER_B);
        add_alu(CMD_EQ, OP_SUB, 5, 5, 0, ST_READY, S_RESULT);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].alu) begin
                exp_q.push_back(pack_txn(vecs[i].op, vecs[i].a, vecs[i].b));
                pushed++;
            end
            send_cmd(vecs[i].c);
            if (vecs[i].alu) wait_exec($sformatf("row%0d_exec", i));
            checks++;
            if (disp_value == DATA_W'(vecs[i].disp) && status == vecs[i].st && state == vecs[i].sv)
                passes++;
            else
                $display("FAIL row%0d: disp=%0d status=%0d state=%0d, expected disp=%0d status=%0d state=%0d",
                         i, disp_value, status, state, vecs[i].disp, vecs[i].st, vecs[i].sv);
        end

        // latency and commands dropped during S_EXEC
        apply_reset();
        send_cmd(4'd1);
        send_cmd(4'd2);
        send_cmd(CMD_ADD);
        send_cmd(4'd3);
        exp_q.push_back(pack_txn(OP_ADD, 12, 3));
        pushed++;
        send_cmd(CMD_EQ);
        c0 = cyc;
        check("eq_alu_start", alu_start, 1);
        check("exec_status_busy", status, ST_BUSY);
        check("exec_cmd_ready", cmd_ready, 0);
        send_cmd(4'd7);
        send_cmd(CMD_CLR);
        wait_exec("latency_exec");
        check("done_to_result_cycles", cyc - c0, 6);
        check("latency_disp", disp_value, 15);
        check("latency_status", status, ST_READY);
        check("latency_state", state, S_RESULT);
        check("latency_alu_start_low", alu_start, 0);

        // alu_done coincident with a CLR strobe: CLR dropped, result honoured
        send_cmd(CMD_ADD);
        send_cmd(4'd5);
        exp_q.push_back(pack_txn(OP_ADD, 15, 5));
        pushed++;
        inject_cmd     = CMD_CLR;
        inject_on_done = 1'b1;
        send_cmd(CMD_EQ);
        wait_exec("coincide_exec");
        check("coincide_disp", disp_value, 20);
        check("coincide_status", status, ST_READY);
        check("coincide_state", state, S_RESULT);
        @(negedge clock);
        check("coincide_state_hold", state, S_RESULT);

        // reset two cycles into S_EXEC, stale done arrives afterwards
        send_cmd(4'd4);
        send_cmd(CMD_ADD);
        send_cmd(4'd4);
        exp_q.push_back(pack_txn(OP_ADD, 4, 4));
        pushed++;
        abort_expected = 1'b1;
        send_cmd(CMD_EQ);
        check("abort_alu_start", alu_start, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        abort_expected = 1'b0;
        check("abort_disp", disp_value, 0);
        check("abort_status", status, ST_READY);
        check("abort_state", state, S_ENTER_A);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_alu_a", alu_a, 0);
        send_cmd(4'd5);
        check("post_abort_disp", disp_value, 5);
        check("post_abort_state", state, S_ENTER_A);

        repeat (4) @(negedge clock);
        check("alu_start_count", start_count, pushed);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
